uart_tx_sched: RTL and testbench

Message-level arbiter that shares the single `uart_tx` serializer between NREQ byte-stream requesters (banner streamer, packet hex dumper, and future status sources). It grants one requester per complete message (terminated by `last`) in round-robin order. It paces bytes into the serializer with a one-cycle `tx_dv` strobe and waits for `tx_done` before fetching the next byte. It sits between the requesters and `uart_tx` in the top-level clock domain.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/uart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: scheduler state encoding, ASCII framing bytes and bit timing.
// The CR/LF states exist only when UART_TX_SCHED_CRLF_EN is defined.
package uart_pkg;

`ifdef UART_TX_SCHED_CRLF_EN
  localparam int unsigned ST_W = 6;
`else
  localparam int unsigned ST_W = 4;
`endif

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE  = state_t'(1);
  localparam state_t ST_LOAD  = state_t'(2);
  localparam state_t ST_START = state_t'(4);
  localparam state_t ST_WAIT  = state_t'(8);
`ifdef UART_TX_SCHED_CRLF_EN
  localparam state_t ST_CR    = state_t'(16);
  localparam state_t ST_LF    = state_t'(32);
`endif

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Rounded integer divide for the serializer baud counter.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int unsigned SYS_CLK_HZ   = 100_000_000;
  localparam int unsigned UART_BAUD    = 115_200;
  localparam int unsigned CLKS_PER_BIT = clks_per_bit(SYS_CLK_HZ, UART_BAUD);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [PW-1:0] idx_c,
  output logic          any_c
);

  logic [PW:0] pos;
  logic        found;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!found && req[pos[PW-1:0]]) begin
        found               = 1'b1;
        gnt_c[pos[PW-1:0]]  = 1'b1;
        idx_c               = pos[PW-1:0];
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Message-level round-robin scheduler feeding one uart_tx serializer from NREQ byte streams.
// Define UART_TX_SCHED_CRLF_EN to append CR LF after every completed message.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned IDLE_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic [NREQ-1:0]   grant,
  output logic              timeout_err
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(IDLE_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr, gidx, next_ptr_c;
  logic [CW-1:0]   idle_cnt;
  logic            last_q;
  logic [NREQ-1:0] arb_gnt_c;
  logic [PW-1:0]   arb_idx_c;
  logic            arb_any_c;
  logic            xfer_c, timeout_c, msg_end_c;
  logic [7:0]      sel_byte_c;
  logic            sel_last_c;
`ifdef UART_TX_SCHED_CRLF_EN
  logic [1:0]      crlf_ph;
  logic            crlf_go_c;
`endif

  rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c),
    .any_c (arb_any_c)
  );

  // Lane of the current owner.
  always_comb begin
    sel_byte_c = '0;
    sel_last_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_byte_c = req_data[8*i +: 8];
        sel_last_c = req_last[i];
      end
    end
  end

  assign xfer_c     = (state_q == ST_LOAD) && |(req_valid & grant);
  assign timeout_c  = (state_q == ST_LOAD) && !xfer_c && (idle_cnt == CW'(IDLE_TIMEOUT - 1));
  assign next_ptr_c = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
`ifdef UART_TX_SCHED_CRLF_EN
  assign crlf_go_c  = (state_q == ST_WAIT) && tx_done && last_q && (crlf_ph != 2'd2);
  assign msg_end_c  = (state_q == ST_WAIT) && tx_done && last_q && (crlf_ph == 2'd2);
`else
  assign msg_end_c  = (state_q == ST_WAIT) && tx_done && last_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_any_c) state_d = ST_LOAD;
      ST_LOAD: begin
        if (xfer_c)         state_d = ST_START;
        else if (timeout_c) state_d = ST_IDLE;
      end
      ST_START: if (!tx_active) state_d = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          if (!last_q) state_d = ST_LOAD;
`ifdef UART_TX_SCHED_CRLF_EN
          else if (crlf_ph == 2'd0) state_d = ST_CR;
          else if (crlf_ph == 2'd1) state_d = ST_LF;
`endif
          else state_d = ST_IDLE;
        end
      end
`ifdef UART_TX_SCHED_CRLF_EN
      ST_CR:    if (!tx_active) state_d = ST_WAIT;
      ST_LF:    if (!tx_active) state_d = ST_WAIT;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobe is held off while the serializer is still busy from an earlier byte.
  always_comb begin
    req_ready = '0;
    tx_dv     = 1'b0;
    unique case (state_q)
      ST_LOAD:  req_ready = grant;
      ST_START: tx_dv     = !tx_active;
`ifdef UART_TX_SCHED_CRLF_EN
      ST_CR:    tx_dv     = !tx_active;
      ST_LF:    tx_dv     = !tx_active;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant       <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      tx_byte     <= 8'h00;
      last_q      <= 1'b0;
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
      crlf_ph     <= 2'd0;
`endif
    end else begin
      if ((state_q == ST_IDLE) && arb_any_c) begin
        grant    <= arb_gnt_c;
        gidx     <= arb_idx_c;
        idle_cnt <= '0;
`ifdef UART_TX_SCHED_CRLF_EN
        crlf_ph  <= 2'd0;
`endif
      end
      if (xfer_c) begin
        tx_byte  <= sel_byte_c;
        last_q   <= sel_last_c;
        idle_cnt <= '0;
      end else if (state_q == ST_LOAD) begin
        if (timeout_c) begin
          timeout_err <= 1'b1;
          grant       <= '0;
          rr_ptr      <= next_ptr_c;
          idle_cnt    <= '0;
        end else if (idle_cnt != CW'(IDLE_TIMEOUT)) begin
          idle_cnt <= idle_cnt + CW'(1);
        end
      end
`ifdef UART_TX_SCHED_CRLF_EN
      if (crlf_go_c) begin
        tx_byte <= (crlf_ph == 2'd0) ? ASCII_CR : ASCII_LF;
        crlf_ph <= crlf_ph + 2'd1;
      end
`endif
      if (msg_end_c) begin
        grant  <= '0;
        rr_ptr <= next_ptr_c;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: message-level round-robin reference model, serializer model,
// directed stall/timeout/reset/busy cases plus randomized batches. Honors UART_TX_SCHED_CRLF_EN.
module tb_uart_tx_sched;
  localparam int unsigned NREQ = 2;
  localparam int unsigned TMO  = 20;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active;
  logic              tx_done = 1'b0;
  logic [NREQ-1:0]   grant;
  logic              timeout_err;
  logic              ser_busy = 1'b0;
  logic              force_busy = 1'b0;

  assign tx_active = ser_busy | force_busy;

  always #5 clk = ~clk;

  uart_tx_sched #(.NREQ(NREQ), .IDLE_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .tx_active(tx_active), .tx_done(tx_done), .grant(grant), .timeout_err(timeout_err)
  );

  typedef struct { logic [7:0] data; logic last; int gap; } ent_t;
  typedef struct { logic [7:0] b; logic [NREQ-1:0] g; } exp_t;

  ent_t rq [NREQ][$];
  ent_t bq [NREQ][$];
  exp_t expq [$];
  exp_t mon_e;

  int   checks = 0, errors = 0;
  int   cyc = 0, m_ptr = 0, ser_lat = 10, ser_cnt = 0;
  logic dv_pend = 1'b0, prev_dv = 1'b0, hold_chk = 1'b0;
  logic [7:0] held = '0;
  int   dv_cnt = 0, dv_cyc = 0;
  logic pend [NREQ];
  logic loaded [NREQ];
  int   gap [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  // Serializer model: busy for ser_lat cycles after the strobe, then a one-cycle done pulse.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (ser_cnt > 0) begin
      ser_cnt--;
      if (ser_cnt == 0) begin ser_busy = 1'b0; tx_done = 1'b1; end
    end
    if (dv_pend) begin ser_busy = 1'b1; ser_cnt = ser_lat; dv_pend = 1'b0; end
    #2 dv_pend = tx_dv;
  end

  // Requesters: present queue head; gap counts granted-but-withheld cycles before a byte.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) begin
        if (rq[i].size() > 0) rq[i].delete(0);
        loaded[i] = 1'b0;
      end
      req_valid[i] = 1'b0;
      if (rq[i].size() > 0) begin
        if (!loaded[i]) begin gap[i] = rq[i][0].gap; loaded[i] = 1'b1; end
        if (gap[i] > 0) begin
          if (req_ready[i]) gap[i]--;
        end else begin
          req_valid[i]          = 1'b1;
          req_data[8*i +: 8]    = rq[i][0].data;
          req_last[i]           = rq[i][0].last;
        end
      end
      pend[i] = req_valid[i] & req_ready[i];
    end
  end

  // Monitor: every strobe pops the scoreboard.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (tx_dv) begin
        checks++;
        if (prev_dv) begin errors++; $display("FAIL dv_width: tx_dv high 2+ cycles, required 1"); end
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_dv: byte %02h grant %b, required no strobe", tx_byte, grant);
        end else begin
          mon_e = expq.pop_front();
          checks++;
          if (tx_byte !== mon_e.b) begin errors++; $display("FAIL tx_byte: got %02h, required %02h", tx_byte, mon_e.b); end
          checks++;
          if (grant !== mon_e.g) begin errors++; $display("FAIL grant_at_dv: got %b, required %b", grant, mon_e.g); end
        end
        held = tx_byte; hold_chk = 1'b1; dv_cnt++; dv_cyc = cyc;
      end
      if (tx_done && hold_chk) begin
        checks++;
        if (tx_byte !== held) begin errors++; $display("FAIL tx_byte_hold: got %02h, required %02h", tx_byte, held); end
        hold_chk = 1'b0;
      end
    end
    prev_dv = tx_dv;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin errors++; $display("FAIL %s: got %0h, required %0h", name, act, req); end
  endtask

  task automatic push_exp(input logic [7:0] b, input int idx);
    exp_t e;
    e.b = b; e.g = '0; e.g[idx] = 1'b1;
    expq.push_back(e);
  endtask

  task automatic push_tail(input int idx);
`ifdef UART_TX_SCHED_CRLF_EN
    push_exp(8'h0D, idx);
    push_exp(8'h0A, idx);
`else
    if (idx < 0) $display("bad index");
`endif
  endtask

  function automatic ent_t mk(input logic [7:0] d, input logic l, input int g);
    ent_t e;
    e.data = d; e.last = l; e.gap = g;
    return e;
  endfunction

  // Reference: whole messages served round-robin from the pointer, owner's priority dropped after.
  task automatic launch();
    ent_t e;
    int   idx, c;
    for (int i = 0; i < NREQ; i++)
      foreach (bq[i][j]) rq[i].push_back(bq[i][j]);
    while (bq[0].size() + bq[1].size() > 0) begin
      idx = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (idx < 0 && bq[c].size() > 0) idx = c;
      end
      do begin
        e = bq[idx].pop_front();
        push_exp(e.data, idx);
      end while (!e.last);
      push_tail(idx);
      m_ptr = (idx + 1) % NREQ;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(rq[0].size() == 0 && rq[1].size() == 0 && expq.size() == 0 &&
             grant == '0 && !tx_active) && n < 5000) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL %s_drain: %0d bytes left after 5000 cycles, required 0", name, expq.size()); end
  endtask

  task automatic wait_rq(input int i, input int sz);
    int n = 0;
    while (rq[i].size() != sz && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL wait_rq%0d: size %0d, required %0d", i, rq[i].size(), sz); end
  endtask

  task automatic wait_dv(input int cnt);
    int n = 0;
    while (dv_cnt < cnt && n < 2000) begin @(negedge clk); #3; n++; end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL wait_dv: count %0d, required %0d", dv_cnt, cnt); end
  endtask

  initial begin
    int base, drop_cyc, nm, len, tot;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; loaded[i] = 1'b0; gap[i] = 0; end
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, drop_cyc, nm, len, tot;
    ent_t e;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_dv", 32'(tx_dv), 0);
    chk("rst_byte", 32'(tx_byte), 0);
    chk("rst_terr", 32'(timeout_err), 0);

    // Single message from req0.
    ser_lat = 10;
    bq[0].push_back(mk(8'h41, 1'b0, 0));
    bq[0].push_back(mk(8'h42, 1'b0, 0));
    bq[0].push_back(mk(8'h43, 1'b1, 0));
    @(negedge clk); #1 launch();
    wait_drain("single");
    chk("single_grant_idle", 32'(grant), 0);

    // Contention: two 2-byte messages each.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) begin
        bq[i].push_back(mk(8'(8'h10 + 16*i + 2*r), 1'b0, 0));
        bq[i].push_back(mk(8'(8'h11 + 16*i + 2*r), 1'b1, 0));
      end
    @(negedge clk); #1 launch();
    wait_drain("contention");

    // Stall just under the limit: message completes without error.
    bq[1].push_back(mk(8'hA1, 1'b0, 0));
    bq[1].push_back(mk(8'hA2, 1'b1, TMO - 1));
    @(negedge clk); #1 launch();
    wait_drain("stall_ok");
    chk("stall_ok_terr", 32'(timeout_err), 0);

    // Stall at the limit: grant revoked, req0 served, req1 resumes as a new message.
    @(negedge clk); #1;
    rq[1].push_back(mk(8'hB1, 1'b0, 0));
    rq[1].push_back(mk(8'hB2, 1'b1, TMO));
    push_exp(8'hB1, 1);
    wait_rq(1, 1);
    #1;
    rq[0].push_back(mk(8'hC1, 1'b0, 0));
    rq[0].push_back(mk(8'hC2, 1'b1, 0));
    push_exp(8'hC1, 0); push_exp(8'hC2, 0); push_tail(0);
    push_exp(8'hB2, 1); push_tail(1);
    m_ptr = 0;
    wait_drain("timeout");
    chk("timeout_terr", 32'(timeout_err), 1);

    // Serializer still busy when START is entered.
    force_busy = 1'b1;
    bq[0].push_back(mk(8'h77, 1'b1, 0));
    @(negedge clk); #1 launch();
    base = dv_cnt;
    wait_rq(0, 0);
    repeat (5) @(negedge clk);
    chk("busy_no_dv", 32'(dv_cnt), 32'(base));
    force_busy = 1'b0;
    drop_cyc = cyc;
    #3;
    chk("busy_dv_count", 32'(dv_cnt), 32'(base + 1));
    chk("busy_dv_cycle", 32'(dv_cyc), 32'(drop_cyc));
    wait_drain("busy");

    // Reset during WAIT; the stale done must not restart anything.
    bq[0].push_back(mk(8'h11, 1'b0, 0));
    bq[0].push_back(mk(8'h22, 1'b0, 0));
    bq[0].push_back(mk(8'h33, 1'b1, 0));
    base = dv_cnt;
    @(negedge clk); #1 launch();
    wait_dv(base + 1);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rq[i].delete(); pend[i] = 1'b0; loaded[i] = 1'b0; end
    expq.delete();
    hold_chk = 1'b0;
    req_valid = '0;
    m_ptr = 0;
    @(negedge clk); #1 reset_n = 1'b1;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_dv", 32'(tx_dv), 0);
    chk("mid_rst_byte", 32'(tx_byte), 0);
    chk("mid_rst_terr", 32'(timeout_err), 0);
    base = dv_cnt;
    repeat (15) @(negedge clk);
    chk("stale_done_dv", 32'(dv_cnt), 32'(base));
    chk("stale_done_grant", 32'(grant), 0);

`ifdef UART_TX_SCHED_CRLF_EN
    // One-byte message followed by CR LF under the same grant.
    bq[0].push_back(mk(8'h5A, 1'b1, 0));
    base = dv_cnt;
    @(negedge clk); #1 launch();
    wait_dv(base + 3);
    begin
      int n = 0;
      while (!tx_done && n < 100) begin @(negedge clk); #3; n++; end
      chk("crlf_done_seen", 32'(n < 100), 1);
    end
    chk("crlf_grant_held", 32'(grant), 1);
    @(negedge clk); #3;
    chk("crlf_grant_free", 32'(grant), 0);
    wait_drain("crlf");
`endif

    // Randomized batches of messages with intra-message gaps and varied serializer latency.
    for (int b = 0; b < 8; b++) begin
      ser_lat = $urandom_range(2, 12);
      tot = 0;
      for (int i = 0; i < NREQ; i++) begin
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 3);
          for (int k = 0; k < len; k++) begin
            e = mk(8'($urandom), k == len - 1, (k == 0) ? 0 : $urandom_range(0, 3));
            bq[i].push_back(e);
            tot++;
          end
        end
      end
      if (tot == 0) bq[$urandom_range(0, 1)].push_back(mk(8'($urandom), 1'b1, 0));
      @(negedge clk); #1 launch();
      wait_drain("random");
    end
    chk("final_terr", 32'(timeout_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
